fetch_thread_scheduler: RTL and testbench

Per-cycle fetch thread selector for the 4-thread fetch unit. Tracks each hardware thread's fetch state and grants one thread per cycle on `o_thread_choice`, which drives the fetch unit's `i_thread_choice`. Arbitration gives priority to threads redirecting after a branch mispredict, and rotates round-robin among ready threads. Threads waiting on an I-cache fill are excluded from arbitration.

---
 rtl/fetch_sched_pkg.sv | 15 +
 rtl/fetch_thread_scheduler_rr_arbiter.sv | 26 ++
 rtl/fetch_thread_scheduler.sv | 150 +++++++++++++++
 tb/tb_fetch_thread_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_sched_pkg.sv
// Shared definitions for the fetch thread scheduler: thread count, thread ID
// width and the per-thread fetch state encoding.
package fetch_sched_pkg;

    localparam int NUM_THREADS = 4;
    localparam int TID_WIDTH   = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READY     = 2'd1,
        MISS_WAIT = 2'd2,
        REDIRECT  = 2'd3
    } thread_state_e;

endpackage

// File: rtl/fetch_thread_scheduler_rr_arbiter.sv
// Four-way round-robin pick: the first set request at or after the start
// pointer, wrapping from 3 to 0. Purely combinational.
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    // Scan the offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        grant = 2'd0;
        valid = 1'b0;
        idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = start + i[1:0];
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_thread_scheduler.sv
// Per-cycle fetch thread selector: per-thread fetch FSMs plus a prioritised
// round-robin grant. Optional starvation guard: FETCH_SCHED_STARVE_GUARD_EN.
module fetch_thread_scheduler #(
    parameter int NUM_THREADS  = 4,
    parameter int TID_WIDTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Stall,
    input  logic [NUM_THREADS-1:0] i_thread_active,
    input  logic                   i_icache_miss,
    input  logic [TID_WIDTH-1:0]   i_icache_miss_tid,
    input  logic [NUM_THREADS-1:0] i_icache_fill,
    input  logic [2*NUM_THREADS-1:0] i_branch_mispredict,
    output logic [TID_WIDTH-1:0]   o_thread_choice,
    output logic                   o_fetch_valid,
    output logic [2*NUM_THREADS-1:0] o_thread_state
);

    import fetch_sched_pkg::*;

    thread_state_e          state_q [NUM_THREADS];
    logic [TID_WIDTH-1:0]   rr_ptr;
    logic [TID_WIDTH-1:0]   last_grant;

    logic [NUM_THREADS-1:0] redirect_mask;
    logic [NUM_THREADS-1:0] ready_mask;
    logic [TID_WIDTH-1:0]   redirect_grant, ready_grant, pick;
    logic                   redirect_valid, ready_valid, any_eligible, grant_fire;

    // Only the even bit of each mispredict pair is meaningful to this block.
    logic unused_mp_odd;
    always_comb begin
        unused_mp_odd = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++)
            unused_mp_odd = unused_mp_odd ^ i_branch_mispredict[2*t+1];
    end

    always_comb begin
        redirect_mask  = '0;
        ready_mask     = '0;
        o_thread_state = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            redirect_mask[t]          = (state_q[t] == REDIRECT);
            ready_mask[t]             = (state_q[t] == READY);
            o_thread_state[2*t +: 2]  = state_q[t];
        end
    end

    rr_arbiter_4 u_redirect_arb (
        .req   (redirect_mask),
        .start (rr_ptr),
        .grant (redirect_grant),
        .valid (redirect_valid)
    );

    rr_arbiter_4 u_ready_arb (
        .req   (ready_mask),
        .start (rr_ptr),
        .grant (ready_grant),
        .valid (ready_valid)
    );

`ifdef FETCH_SCHED_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT) + 1;

    logic [CW-1:0]          starve_cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0] starve_mask;
    logic [TID_WIDTH-1:0]   starve_grant;
    logic                   starve_valid;

    always_comb begin
        starve_mask = '0;
        for (int t = 0; t < NUM_THREADS; t++)
            starve_mask[t] = ready_mask[t] && (starve_cnt[t] == CW'(STARVE_LIMIT));
    end

    rr_arbiter_4 u_starve_arb (
        .req   (starve_mask),
        .start (rr_ptr),
        .grant (starve_grant),
        .valid (starve_valid)
    );

    // A starved READY thread outranks REDIRECT; starved threads are a subset of READY.
    always_comb begin
        any_eligible = redirect_valid || ready_valid;
        if (starve_valid)
            pick = starve_grant;
        else if (redirect_valid)
            pick = redirect_grant;
        else
            pick = ready_grant;
    end

    always_ff @(posedge i_Clk) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (i_Reset)
                starve_cnt[t] <= '0;
            else if (state_q[t] != READY || (grant_fire && pick == TID_WIDTH'(t)))
                starve_cnt[t] <= '0;
            else if (starve_cnt[t] != CW'(STARVE_LIMIT))
                starve_cnt[t] <= starve_cnt[t] + 1'b1;
        end
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    always_comb begin
        any_eligible = redirect_valid || ready_valid;
        pick         = redirect_valid ? redirect_grant : ready_grant;
    end
`endif

    assign grant_fire      = any_eligible && !i_Stall;
    assign o_fetch_valid   = grant_fire;
    assign o_thread_choice = any_eligible ? pick : last_grant;

    // Per-thread FSM; the if-chain order is the transition priority.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            rr_ptr     <= '0;
            last_grant <= '0;
            for (int t = 0; t < NUM_THREADS; t++)
                state_q[t] <= IDLE;
        end else begin
            if (grant_fire) begin
                rr_ptr     <= pick + 1'b1;
                last_grant <= pick;
            end
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (!i_thread_active[t])
                    state_q[t] <= IDLE;
                else if (i_branch_mispredict[2*t] && state_q[t] != IDLE)
                    state_q[t] <= REDIRECT;
                else if (state_q[t] == READY && i_icache_miss &&
                         i_icache_miss_tid == TID_WIDTH'(t))
                    state_q[t] <= MISS_WAIT;
                else if (state_q[t] == MISS_WAIT && i_icache_fill[t])
                    state_q[t] <= READY;
                else if (state_q[t] == REDIRECT && grant_fire && pick == TID_WIDTH'(t))
                    state_q[t] <= READY;
                else if (state_q[t] == IDLE)
                    state_q[t] <= READY;
            end
        end
    end

endmodule

// File: tb/tb_fetch_thread_scheduler.sv
// Directed bench for fetch_thread_scheduler: a per-cycle vector table plus
// hand-written reset-mid-run and starvation sequences.
module tb_fetch_thread_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [3:0] active;
    logic       miss;
    logic [1:0] miss_tid;
    logic [3:0] fill;
    logic [7:0] mp;
    logic [1:0] choice;
    logic       fvalid;
    logic [7:0] tstate;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_thread_scheduler #(
        .NUM_THREADS  (4),
        .TID_WIDTH    (2),
        .STARVE_LIMIT (8)
    ) dut (
        .i_Clk               (clk),
        .i_Reset             (rst),
        .i_Stall             (stall),
        .i_thread_active     (active),
        .i_icache_miss       (miss),
        .i_icache_miss_tid   (miss_tid),
        .i_icache_fill       (fill),
        .i_branch_mispredict (mp),
        .o_thread_choice     (choice),
        .o_fetch_valid       (fvalid),
        .o_thread_state      (tstate)
    );

    typedef struct {
        logic       stall;
        logic [3:0] active;
        logic       miss;
        logic [1:0] mtid;
        logic [3:0] fill;
        logic [7:0] mp;
        logic [1:0] exp_choice;
        logic       exp_valid;
        logic [7:0] exp_state;
    } vec_t;

    vec_t vecs [37];

    function automatic vec_t mk(input logic s, input logic [3:0] a, input logic m,
                                input logic [1:0] mt, input logic [3:0] f,
                                input logic [7:0] p, input logic [1:0] ec,
                                input logic ev, input logic [7:0] es);
        vec_t v;
        v.stall = s; v.active = a; v.miss = m; v.mtid = mt; v.fill = f; v.mp = p;
        v.exp_choice = ec; v.exp_valid = ev; v.exp_state = es;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall    = v.stall;
        active   = v.active;
        miss     = v.miss;
        miss_tid = v.mtid;
        fill     = v.fill;
        mp       = v.mp;
    endtask

    int  last0, gap_max, grants0;
    bit  seen0;

    initial begin
        // Inputs for each cycle, then the outputs expected in that same cycle.
        vecs[0]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 0, 8'h00);
        vecs[1]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 1, 8'h55);
        vecs[2]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 1, 1, 8'h55);
        vecs[3]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 2, 1, 8'h55);
        vecs[4]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 3, 1, 8'h55);
        vecs[5]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 1, 8'h55);
        vecs[6]  = mk(0, 4'hF, 1, 1, 4'h0, 8'h00, 1, 1, 8'h55);
        vecs[7]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 2, 1, 8'h59);
        vecs[8]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 3, 1, 8'h59);
        vecs[9]  = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 1, 8'h59);
        vecs[10] = mk(0, 4'hF, 0, 0, 4'h2, 8'h00, 2, 1, 8'h59);
        vecs[11] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 3, 1, 8'h55);
        vecs[12] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 1, 8'h55);
        vecs[13] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 1, 1, 8'h55);
        vecs[14] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 2, 1, 8'h55);
        vecs[15] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 3, 1, 8'h55);
        vecs[16] = mk(0, 4'hF, 0, 0, 4'h0, 8'h10, 0, 1, 8'h55);
        vecs[17] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 2, 1, 8'h75);
        vecs[18] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 3, 1, 8'h55);
        vecs[19] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 1, 8'h55);
        vecs[20] = mk(0, 4'hF, 1, 3, 4'h0, 8'h40, 1, 1, 8'h55);
        vecs[21] = mk(1, 4'hF, 0, 0, 4'h8, 8'h00, 3, 0, 8'hD5);
        vecs[22] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 3, 1, 8'hD5);
        vecs[23] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 1, 8'h55);
        vecs[24] = mk(0, 4'hF, 0, 0, 4'h0, 8'h04, 1, 1, 8'h55);
        vecs[25] = mk(1, 4'hF, 0, 0, 4'h0, 8'h00, 1, 0, 8'h5D);
        vecs[26] = mk(1, 4'hF, 1, 1, 4'h0, 8'h00, 1, 0, 8'h5D);
        vecs[27] = mk(1, 4'hF, 0, 0, 4'h0, 8'h00, 1, 0, 8'h5D);
        vecs[28] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 1, 1, 8'h5D);
        vecs[29] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 2, 1, 8'h55);
        vecs[30] = mk(0, 4'h7, 0, 0, 4'h0, 8'h00, 3, 1, 8'h55);
        vecs[31] = mk(0, 4'h7, 0, 0, 4'h0, 8'h00, 0, 1, 8'h15);
        vecs[32] = mk(0, 4'h0, 0, 0, 4'h0, 8'h00, 1, 1, 8'h15);
        vecs[33] = mk(0, 4'h0, 0, 0, 4'h0, 8'h00, 1, 0, 8'h00);
        vecs[34] = mk(0, 4'h1, 0, 0, 4'h0, 8'h00, 1, 0, 8'h00);
        vecs[35] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 0, 1, 8'h01);
        vecs[36] = mk(0, 4'hF, 0, 0, 4'h0, 8'h00, 1, 1, 8'h55);

        // Clock/reset
        rst = 1'b1; stall = 1'b0; active = 4'h0; miss = 1'b0;
        miss_tid = 2'd0; fill = 4'h0; mp = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_choice", 0, {6'd0, choice}, 8'h00);
        check("reset_valid",  0, {7'd0, fvalid}, 8'h00);
        check("reset_state",  0, tstate, 8'h00);
        rst = 1'b0;

        // Table-driven main sequence
        for (int i = 0; i < 37; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check("choice", i, {6'd0, choice}, {6'd0, vecs[i].exp_choice});
            check("valid",  i, {7'd0, fvalid}, {7'd0, vecs[i].exp_valid});
            check("state",  i, tstate, vecs[i].exp_state);
            @(posedge clk);
            #1;
        end

        // Reset mid-operation beats simultaneous events
        rst = 1'b1; active = 4'hF; mp = 8'hFF; miss = 1'b1; miss_tid = 2'd1; fill = 4'hF;
        @(posedge clk);
        #1;
        check("midrst_state",  0, tstate, 8'h00);
        check("midrst_valid",  0, {7'd0, fvalid}, 8'h00);
        check("midrst_choice", 0, {6'd0, choice}, 8'h00);

        // Starvation: threads 1-3 mispredict every cycle
        rst = 1'b0; miss = 1'b0; fill = 4'h0; mp = 8'h54;
        seen0 = 1'b0; last0 = 0; gap_max = 0; grants0 = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (fvalid && choice == 2'd0) begin
                if (seen0 && (c - last0) > gap_max)
                    gap_max = c - last0;
                seen0 = 1'b1;
                last0 = c;
                grants0++;
            end
            @(posedge clk);
            #1;
        end
`ifdef FETCH_SCHED_STARVE_GUARD_EN
        check("starve_grants", 0, 8'(grants0 >= 3), 8'd1);
        check("starve_gap",    0, 8'(gap_max), 8'(gap_max <= 9 ? gap_max : 9));
`else
        check("starve_grants", 0, 8'(grants0), 8'd1);
`endif
        mp = 8'h00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
